// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, ALU codes,
// FSM states, instruction classes and the control-word layout.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    // T0..T7 are consecutive so the FSM can step with +1.
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_BR, C_JR, C_IN, C_OUT, C_HALT
    } iclass_t;

    typedef struct packed {
        logic pc_out, zhi_out, zlow_out, mdr_out, inport_out, c_out;
        logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, outport_in, con_in;
        logic inc_pc, read, write, gra, grb, grc, r_in, r_out, ba_out, strobe;
        logic [3:0] alu_op;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps a 5-bit opcode to its execution class and the ALU operation it uses.
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output iclass_t    cls_o,
    output logic [3:0] alu_op_o
);
    always_comb begin
        cls_o    = C_NOP;
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_LD:   cls_o = C_LD;
            OP_LDI:  cls_o = C_LDI;
            OP_ST:   cls_o = C_ST;
            OP_ADD:  cls_o = C_ALU;
            OP_SUB:  begin cls_o = C_ALU; alu_op_o = ALU_SUB; end
            OP_AND:  begin cls_o = C_ALU; alu_op_o = ALU_AND; end
            OP_OR:   begin cls_o = C_ALU; alu_op_o = ALU_OR;  end
            OP_ADDI: cls_o = C_IMM;
            OP_ANDI: begin cls_o = C_IMM; alu_op_o = ALU_AND; end
            OP_ORI:  begin cls_o = C_IMM; alu_op_o = ALU_OR;  end
            OP_BR:   cls_o = C_BR;
            OP_JR:   cls_o = C_JR;
            OP_IN:   cls_o = C_IN;
            OP_OUT:  cls_o = C_OUT;
            OP_HALT: cls_o = C_HALT;
            default: cls_o = C_NOP;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit: Moore FSM stepping T0..T7 with outputs
// decoded from the state register and the instruction class.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout, Zhiout, Zlowout, MDRout, InPortout, Cout,
    output logic        MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn,
    output logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Strobe,
    output logic [3:0]  ALUop,
    output logic        Run
);
    state_t     state_q, state_d;
    iclass_t    cls_dec, cls_q, cls;
    logic [3:0] alu_dec, alu_q;
    logic       last;
    ctrl_t      ctl;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];

    instr_class_decode u_dec (
        .opcode_i (IR[31:27]),
        .cls_o    (cls_dec),
        .alu_op_o (alu_dec)
    );

    // IR is first trusted in T3; the class is held from then on so later
    // states do not depend on IR staying stable.
    assign cls = (state_q == S_T3) ? cls_dec : cls_q;

    always_comb begin
        last = 1'b0;
        case (state_q)
            S_T3: last = (cls == C_JR) || (cls == C_IN) || (cls == C_OUT) || (cls == C_NOP);
            S_T5: last = (cls == C_LDI) || (cls == C_ALU) || (cls == C_IMM);
            S_T6: last = (cls == C_BR);
            S_T7: last = 1'b1;
            default: last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: begin
                if (state_q == S_T3 && cls == C_HALT) state_d = S_HALT;
                else if (last)                       state_d = Stop ? S_HALT : S_T0;
                else                                 state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= S_RESET;
            cls_q   <= C_NOP;
            alu_q   <= ALU_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == S_T3) begin
                cls_q <= cls_dec;
                alu_q <= alu_dec;
            end
        end
    end

    always_comb begin
        ctl     = '0;
        ctl.run = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1; end
            S_T1: begin ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
            S_T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
            S_T3: case (cls)
                C_LD, C_LDI, C_ST: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
                C_ALU, C_IMM: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
                C_BR:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
                C_JR:  begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
                C_IN:  begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                C_OUT: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; ctl.strobe = 1'b1; end
                default: ;
            endcase
            S_T4: case (cls)
                C_LD, C_LDI, C_ST: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = ALU_ADD; end
                C_ALU: begin ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = alu_q; end
                C_IMM: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = alu_q; end
                C_BR:  begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
                default: ;
            endcase
            S_T5: case (cls)
                C_LD, C_ST: begin ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1; end
                C_LDI, C_ALU, C_IMM: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                C_BR: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = ALU_ADD; end
                default: ;
            endcase
            S_T6: case (cls)
                C_LD: begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
                C_ST: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; end
                C_BR: begin ctl.zlow_out = CON_FF; ctl.pc_in = CON_FF; end
                default: ;
            endcase
            S_T7: case (cls)
                C_LD: begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                C_ST: ctl.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

    assign {PCout, Zhiout, Zlowout, MDRout, InPortout, Cout}            = {ctl.pc_out, ctl.zhi_out, ctl.zlow_out, ctl.mdr_out, ctl.inport_out, ctl.c_out};
    assign {MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn}       = {ctl.mar_in, ctl.z_in, ctl.pc_in, ctl.mdr_in, ctl.ir_in, ctl.y_in, ctl.outport_in, ctl.con_in};
    assign {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Strobe} = {ctl.inc_pc, ctl.read, ctl.write, ctl.gra, ctl.grb, ctl.grc, ctl.r_in, ctl.r_out, ctl.ba_out, ctl.strobe};
    assign ALUop = ctl.alu_op;
    assign Run   = ctl.run;

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: an instruction-level model
// predicts the control word for every cycle; a monitor compares at negedge.
module tb_control_unit;

    localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011,
                           SUB = 5'b00100, AND_ = 5'b01001, OR_ = 5'b01010, ADDI = 5'b01011,
                           ANDI = 5'b01100, ORI = 5'b01101, BR = 5'b10010, JR = 5'b10011,
                           IN_ = 5'b10101, OUT_ = 5'b10110, NOP = 5'b11001, HALT = 5'b11010;
    localparam int NCYC = 2500;

    typedef struct packed {
        logic pcout, zhiout, zlowout, mdrout, inportout, cout;
        logic marin, zin, pcin, mdrin, irin, yin, outportin, conin;
        logic incpc, read, write, gra, grb, grc, rin, rout, baout, strobe;
        logic [3:0] aluop;
        logic run;
    } sig_t;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stop;
        int          clr_step;
        logic        rnd;
    } plan_t;

    logic Clock = 1'b0, Clear, CON_FF, Stop;
    logic [31:0] IR;
    logic PCout, Zhiout, Zlowout, MDRout, InPortout, Cout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Strobe;
    logic [3:0] ALUop;
    logic Run;

    sig_t  got;
    sig_t  expq[$];
    plan_t plans[$];
    int    total = 0, bad = 0;

    always #5 Clock = ~Clock;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .InPortout(InPortout), .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .OutPortin(OutPortin), .CONIn(CONIn),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Strobe(Strobe), .ALUop(ALUop), .Run(Run)
    );

    assign got = {PCout, Zhiout, Zlowout, MDRout, InPortout, Cout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn,
                  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Strobe, ALUop, Run};

    // Number of T-states an instruction occupies (T0 counted as step 0).
    function automatic int ilen(input logic [4:0] op);
        case (op)
            LD, ST: return 8;
            LDI, ADD, SUB, AND_, OR_, ADDI, ANDI, ORI: return 6;
            BR: return 7;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] aluof(input logic [4:0] op);
        case (op)
            SUB: return 4'd1;
            AND_, ANDI: return 4'd2;
            OR_, ORI: return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    // mode: 0 = reset, 1 = executing, 2 = halted
    function automatic sig_t exp_sig(input int mode, input int step, input logic [4:0] op, input logic con);
        sig_t s = '0;
        if (mode != 1) return s;
        s.run = 1'b1;
        if (step == 0) begin s.pcout = 1; s.marin = 1; s.incpc = 1; s.zin = 1; end
        else if (step == 1) begin s.zlowout = 1; s.pcin = 1; s.read = 1; s.mdrin = 1; end
        else if (step == 2) begin s.mdrout = 1; s.irin = 1; end
        else case (op)
            LD, LDI, ST: case (step)
                3: begin s.grb = 1; s.baout = 1; s.yin = 1; end
                4: begin s.cout = 1; s.zin = 1; end
                5: if (op == LDI) begin s.zlowout = 1; s.gra = 1; s.rin = 1; end
                   else begin s.zlowout = 1; s.marin = 1; end
                6: if (op == LD) begin s.read = 1; s.mdrin = 1; end
                   else begin s.gra = 1; s.rout = 1; s.mdrin = 1; end
                7: if (op == LD) begin s.mdrout = 1; s.gra = 1; s.rin = 1; end
                   else s.write = 1;
                default: ;
            endcase
            ADD, SUB, AND_, OR_, ADDI, ANDI, ORI: case (step)
                3: begin s.grb = 1; s.rout = 1; s.yin = 1; end
                4: begin
                    s.zin = 1; s.aluop = aluof(op);
                    if (op == ADDI || op == ANDI || op == ORI) s.cout = 1;
                    else begin s.grc = 1; s.rout = 1; end
                end
                5: begin s.zlowout = 1; s.gra = 1; s.rin = 1; end
                default: ;
            endcase
            BR: case (step)
                3: begin s.gra = 1; s.rout = 1; s.conin = 1; end
                4: begin s.pcout = 1; s.yin = 1; end
                5: begin s.cout = 1; s.zin = 1; end
                6: begin s.zlowout = con; s.pcin = con; end
                default: ;
            endcase
            JR:   begin s.gra = 1; s.rout = 1; s.pcin = 1; end
            IN_:  begin s.inportout = 1; s.gra = 1; s.rin = 1; end
            OUT_: begin s.gra = 1; s.rout = 1; s.outportin = 1; s.strobe = 1; end
            default: ;
        endcase
        return s;
    endfunction

    function automatic plan_t mk(input logic [4:0] op, input logic con, input logic stop, input int clr, input logic rnd);
        plan_t p;
        logic [31:0] r;
        r = $urandom();
        p.ir = {op, r[26:0]};
        p.con = con; p.stop = stop; p.clr_step = clr; p.rnd = rnd;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        logic [4:0] ops [18] = '{LD, LDI, ST, ADD, SUB, AND_, OR_, ADDI, ANDI, ORI,
                                 BR, JR, IN_, OUT_, NOP, HALT, 5'b11111, 5'b00101};
        return mk(ops[$urandom_range(0, 17)], 1'b0, 1'b0, -1, 1'b1);
    endfunction

    // Monitor: the DUT presents a control word every cycle.
    initial begin
        sig_t e;
        forever begin
            @(negedge Clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL ctl_word t=%0t got=%h want=%h", $time, got, e);
                end
            end
        end
    end

    initial begin
        int mode = 0, step = 0, halt_cnt = 0;
        logic [4:0] cur_op = 5'd0;
        plan_t cur;
        cur = '{ir: 32'd0, con: 1'b0, stop: 1'b0, clr_step: -1, rnd: 1'b0};
        Clear = 1'b0; IR = 32'd0; CON_FF = 1'b0; Stop = 1'b0;

        plans.push_back('{ir: 32'h00800055, con: 1'b0, stop: 1'b0, clr_step: -1, rnd: 1'b0});
        plans.push_back('{ir: 32'h18910000, con: 1'b0, stop: 1'b0, clr_step: -1, rnd: 1'b0});
        plans.push_back(mk(BR, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(BR, 1'b1, 1'b0, -1, 1'b0));
        plans.push_back(mk(ST, 1'b0, 1'b0, 6, 1'b0));
        plans.push_back(mk(LDI, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(SUB, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(ORI, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(JR, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(IN_, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(OUT_, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(5'b11111, 1'b0, 1'b0, -1, 1'b0));
        plans.push_back(mk(ADDI, 1'b0, 1'b1, -1, 1'b0));
        plans.push_back(mk(HALT, 1'b0, 1'b0, -1, 1'b0));

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge Clock);
            #1;
            // advance the instruction-level model with the inputs seen at this edge
            if (!Clear) mode = 0;
            else if (mode == 0) begin mode = 1; step = 0; end
            else if (mode == 1) begin
                if (step == ilen(cur_op) - 1) begin
                    if (cur_op == HALT || Stop) mode = 2;
                    else step = 0;
                end else step++;
            end
            halt_cnt = (mode == 2) ? halt_cnt + 1 : 0;

            if (mode == 1 && step == 0) begin
                cur = (plans.size() > 0) ? plans.pop_front() : rand_plan();
                IR = cur.ir;
                cur_op = cur.ir[31:27];
            end

            CON_FF = cur.rnd ? 1'($urandom_range(0, 1)) : cur.con;
            Stop   = cur.stop | (cur.rnd && $urandom_range(0, 11) == 0);
            if (cyc < 1) Clear = 1'b0;
            else if (mode == 1 && step == cur.clr_step) Clear = 1'b0;
            else if (mode == 2 && halt_cnt >= 2) Clear = 1'b0;
            else if (cur.rnd && $urandom_range(0, 79) == 0) Clear = 1'b0;
            else Clear = 1'b1;

            expq.push_back(exp_sig(mode, step, cur_op, CON_FF));
        end

        @(negedge Clock);
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide: Clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide: Clear  input  1  synchronous active-low reset, sampled on rising Clock.
REQ-003 SHALL provide: IR  input  32  instruction register contents; opcode = IR[31:27].
REQ-004 SHALL provide: CON_FF  input  1  branch-condition flip-flop from datapath.
REQ-005 SHALL provide: Stop  input  1  request to halt after current instruction completes.
REQ-006 SHALL provide: PCout, Zhiout, Zlowout, MDRout, InPortout, Cout  output  1 each  bus-driver selects.
REQ-007 SHALL provide: MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn  output  1 each  register load enables.
REQ-008 SHALL provide: IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Strobe  output  1 each  datapath controls.
REQ-009 SHALL provide: ALUop  output  4  ALU operation select (ADD=0, SUB=1, AND=2, OR=3, others reserved).
REQ-010 SHALL provide: Run  output  1  high while executing, low in RESET and HALT.

Function
REQ-011 Outputs SHALL be Moore, decoded combinationally from state register only; any output not listed for a state SHALL be 0.
REQ-012 States: RESET, T0..T7, HALT; each T-state SHALL last exactly one Clock cycle.
REQ-013 RESET SHALL advance to T0 on first edge with Clear=1.
REQ-014 Fetch: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,Read,MDRin; T2 MDRout,IRin; T2->T3 always.
REQ-015 Decode SHALL occur in T3 using IR (valid from T3 onward); ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=01001, or=01010, addi=01011, andi=01100, ori=01101, br=10010, jr=10011, in=10101, out=10110, nop=11001, halt=11010.
REQ-016 ld: T3 Grb,BAout,Yin; T4 Cout,ALUop=ADD,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
REQ-017 ldi: T3,T4 as ld; T5 Zlowout,Gra,Rin.
REQ-018 st: T3-T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write.
REQ-019 add/sub/and/or: T3 Grb,Rout,Yin; T4 Grc,Rout,ALUop,Zin; T5 Zlowout,Gra,Rin.
REQ-020 addi/andi/ori: T3 Grb,Rout,Yin; T4 Cout,ALUop,Zin; T5 Zlowout,Gra,Rin.
REQ-021 br: T3 Gra,Rout,CONIn; T4 PCout,Yin; T5 Cout,ALUop=ADD,Zin; T6 Zlowout,PCin only if CON_FF=1 sampled in T6, else no enables.
REQ-022 jr: T3 Gra,Rout,PCin. in: T3 InPortout,Gra,Rin. out: T3 Gra,Rout,OutPortin,Strobe.
REQ-023 nop and unlisted opcodes SHALL execute T3 with no enables and complete.
REQ-024 After the final state of an instruction, next state SHALL be T0, or HALT if Stop=1 on that edge.
REQ-025 halt SHALL transition T3->HALT; HALT SHALL persist until Clear=0; Stop SHALL be ignored mid-instruction.

Reset
REQ-026 Clear=0 at any edge, including mid-instruction, SHALL force RESET on that edge, overriding all other transitions.
REQ-027 In RESET all outputs SHALL be 0, ALUop=0, Run=0; no partial bus cycle SHALL resume afterward.

Structure
REQ-028 Opcode constants, ALUop codes and state encodings SHALL reside in shared package cpu_pkg.
REQ-029 One sub-module, instr_class_decode, SHALL map opcode to instruction class and ALUop.

Verification
REQ-030 Clear=0 two cycles, then 1 -> RESET held, all outputs 0; T0 next cycle, Run=1.
REQ-031 IR=0x00800055 (ld R1,0x55(R0)) -> 8 cycles T0-T7, exact signal sets per REQ-014/016, back to T0.
REQ-032 IR=0x18910000 (add R1,R2,R2) -> T5 Zlowout,Gra,Rin; ALUop=0 in T4; total 6 cycles.
REQ-033 br with CON_FF=0 then CON_FF=1 -> PCin absent then present in T6.
REQ-034 Clear=0 during T6 of st -> Write never asserted, RESET next cycle.
REQ-035 Stop=1 during T4 of addi, and IR opcode 11010 -> HALT after instruction end, Run=0, outputs 0.
